// File: rtl/gate_bank_exerciser.sv
// gate_bank_exerciser: exhaustive stimulus generator and response checker for
// a combinational NOT/AND/NAND/OR/NOR/XOR/XNOR gate bank. A start pulse sweeps
// every {a,b} operand pair, compares the returned results against locally
// computed values and reports pass/fail, a mismatch count, a per-function
// fail mask and the operands of the first failing vector.
module gate_bank_exerciser #(
  parameter int DATA_WIDTH = 4,
  parameter int RESULT_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_in,
  output logic [DATA_WIDTH-1:0]   a_out,
  output logic [DATA_WIDTH-1:0]   b_out,
  input  logic [DATA_WIDTH-1:0]   not_in,
  input  logic [DATA_WIDTH-1:0]   and_in,
  input  logic [DATA_WIDTH-1:0]   nand_in,
  input  logic [DATA_WIDTH-1:0]   or_in,
  input  logic [DATA_WIDTH-1:0]   nor_in,
  input  logic [DATA_WIDTH-1:0]   xor_in,
  input  logic [DATA_WIDTH-1:0]   xnor_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    pass_out,
  output logic [2*DATA_WIDTH:0]   err_count_out,
  output logic [6:0]              fail_mask_out,
  output logic [DATA_WIDTH-1:0]   first_fail_a_out,
  output logic [DATA_WIDTH-1:0]   first_fail_b_out
);

  localparam int VW = 2 * DATA_WIDTH;
  localparam int CW = VW + 1;
  localparam logic [1:0] DRAIN_LAST = 2'(RESULT_LAT > 0 ? RESULT_LAT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // The operand registers double as the vector counter: {a,b} counts 0..N-1.
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_valid;
  logic [1:0]            r_drain_cnt;

  logic [CW-1:0]         r_err;
  logic [6:0]            r_mask;
  logic [DATA_WIDTH-1:0] r_ff_a;
  logic [DATA_WIDTH-1:0] r_ff_b;
  logic                  r_pass;

  logic                  w_start;
  logic                  w_last;
  logic [VW-1:0]         w_v_inc;
  logic [DATA_WIDTH-1:0] w_ea;
  logic [DATA_WIDTH-1:0] w_eb;
  logic                  w_ev;
  logic [DATA_WIDTH-1:0] w_exp [7];
  logic [DATA_WIDTH-1:0] w_got [7];
  logic [6:0]            w_mis;
  logic                  w_hit;
  logic [CW-1:0]         w_err_next;

  assign w_start = (r_state == S_IDLE) && start_in;
  assign w_last  = (&r_a) && (&r_b);
  assign w_v_inc = {r_a, r_b} + {{(VW-1){1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode: RUN ends after the all-ones vector, DRAIN covers the result latency
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = (RESULT_LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Vector generator: operands step once per RUN cycle and wrap to 0 after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
    end else if (w_start) begin
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b1;
    end else if (r_state == S_RUN) begin
      {r_a, r_b} <= w_v_inc;
      r_valid    <= !w_last;
    end
  end

  // Drain cycle counter, held at zero outside DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_drain_cnt <= 2'd0;
    else if (r_state != S_DRAIN) r_drain_cnt <= 2'd0;
    else                         r_drain_cnt <= r_drain_cnt + 2'd1;
  end

  // Operand/valid delay line matching the gate bank's result latency
  if (RESULT_LAT > 0) begin : g_dl
    logic [DATA_WIDTH-1:0] r_dl_a [RESULT_LAT];
    logic [DATA_WIDTH-1:0] r_dl_b [RESULT_LAT];
    logic [RESULT_LAT-1:0] r_dl_v;

    // Shift operands and the valid flag one stage per clock
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RESULT_LAT; i++) begin
          r_dl_a[i] <= '0;
          r_dl_b[i] <= '0;
        end
        r_dl_v <= '0;
      end else begin
        r_dl_a[0] <= r_a;
        r_dl_b[0] <= r_b;
        r_dl_v[0] <= r_valid;
        for (int i = 1; i < RESULT_LAT; i++) begin
          r_dl_a[i] <= r_dl_a[i-1];
          r_dl_b[i] <= r_dl_b[i-1];
          r_dl_v[i] <= r_dl_v[i-1];
        end
      end
    end

    assign w_ea = r_dl_a[RESULT_LAT-1];
    assign w_eb = r_dl_b[RESULT_LAT-1];
    assign w_ev = r_dl_v[RESULT_LAT-1];
  end else begin : g_nodl
    assign w_ea = r_a;
    assign w_eb = r_b;
    assign w_ev = r_valid;
  end

  // Expected and returned results, indexed in fail-mask bit order
  assign w_exp[0] = ~w_ea;
  assign w_exp[1] = w_ea & w_eb;
  assign w_exp[2] = ~(w_ea & w_eb);
  assign w_exp[3] = w_ea | w_eb;
  assign w_exp[4] = ~(w_ea | w_eb);
  assign w_exp[5] = w_ea ^ w_eb;
  assign w_exp[6] = ~(w_ea ^ w_eb);

  assign w_got[0] = not_in;
  assign w_got[1] = and_in;
  assign w_got[2] = nand_in;
  assign w_got[3] = or_in;
  assign w_got[4] = nor_in;
  assign w_got[5] = xor_in;
  assign w_got[6] = xnor_in;

  for (genvar gi = 0; gi < 7; gi++) begin : g_cmp
    assign w_mis[gi] = (w_got[gi] != w_exp[gi]);
  end

  assign w_hit      = w_ev && (|w_mis);
  assign w_err_next = r_err + {{(CW-1){1'b0}}, w_hit};

  // Result accumulation; pass is latched on entry to DONE so it includes the final check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= '0;
      r_mask <= '0;
      r_ff_a <= '0;
      r_ff_b <= '0;
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_err  <= '0;
      r_mask <= '0;
      r_ff_a <= '0;
      r_ff_b <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_hit) begin
        r_err  <= w_err_next;
        r_mask <= r_mask | w_mis;
        if (r_err == '0) begin
          r_ff_a <= w_ea;
          r_ff_b <= w_eb;
        end
      end
      if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
        r_pass <= (w_err_next == '0);
      end
    end
  end

  assign a_out            = r_a;
  assign b_out            = r_b;
  assign busy_out         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_out         = (r_state == S_DONE);
  assign pass_out         = r_pass;
  assign err_count_out    = r_err;
  assign fail_mask_out    = r_mask;
  assign first_fail_a_out = r_ff_a;
  assign first_fail_b_out = r_ff_b;

endmodule

// File: doc/gate_bank_exerciser.md
# gate_bank_exerciser

Sequential stimulus generator and response checker for the combinational bitwise gate bank (NOT/AND/NAND/OR/NOR/XOR/XNOR over DATA_WIDTH-bit operands). On a start pulse it drives every operand pair {a,b} exhaustively into the gate bank and collects the seven returned results. It compares each result bit-exactly against internally computed expected values and reports pass/fail, a mismatch count, a per-function fail mask and the first failing vector. It sits beside the gate bank in the bring-up/BIST path.

## Interface
- DATA_WIDTH, 4: operand width; legal 1..8.
- RESULT_LAT, 0: clock cycles between a vector appearing on a_out/b_out and its results being valid on the *_in ports; legal 0..3.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle start request; honoured only in IDLE.
- a_out, b_out  output  DATA_WIDTH each  registered operands to the gate bank.
- not_in, and_in, nand_in, or_in, nor_in, xor_in, xnor_in  input  DATA_WIDTH each  gate bank results.
- busy_out  output  1  high from the start acceptance through the end of DRAIN.
- done_out  output  1  one-cycle completion pulse.
- pass_out  output  1  err_count_out==0 at completion; held until the next start.
- err_count_out  output  2*DATA_WIDTH+1  number of vectors with at least one mismatching function.
- fail_mask_out  output  7  sticky per-function mismatch flags, bits [6:0] = {xnor,xor,nor,or,nand,and,not}.
- first_fail_a_out, first_fail_b_out  output  DATA_WIDTH each  operands of the first mismatching vector.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - Outputs hold their values from the last run.
  - When start_in=1: clear err_count, fail_mask, first_fail and pass_out; set vector counter v={a,b}=0; go to RUN.
- **RUN**
  - {a_out,b_out} = v, with a in the MSBs; v increments by 1 each cycle.
  - After the cycle that presents v = all ones (N = 2^(2*DATA_WIDTH) vectors), go to DRAIN if RESULT_LAT>0, else DONE.
- **DRAIN**
  - Lasts RESULT_LAT cycles.
  - a_out/b_out return to 0. Vectors issued during this time are not checked.
- **DONE**
  - Lasts one cycle: done_out=1, busy_out=0, pass_out updated.
  - Then go to IDLE.
- **Checking**
  - A RESULT_LAT-deep delay line carries operands and a valid bit.
  - When the delayed valid bit is set, compare the inputs against the delayed operands (ea, eb):
    - not = ~ea
    - and = ea&eb
    - nand = ~(ea&eb)
    - or = ea|eb
    - nor = ~(ea|eb)
    - xor = ea^eb
    - xnor = ~(ea^eb)
  - On any mismatch:
    - err_count increments by 1 per vector, not per function.
    - Failing function bits are OR-ed into fail_mask.
    - If err_count was 0, capture first_fail_a/b = ea/eb.
  - err_count cannot overflow: its maximum is N.
- start_in in RUN, DRAIN or DONE is ignored; there is no queueing.
- Reset mid-operation aborts the run. All state and outputs return to reset values. The next start runs all N vectors.

## Timing
- Reset values: state IDLE; a_out, b_out, busy_out, done_out, pass_out, err_count_out, fail_mask_out, first_fail_* all 0; delay line valid bits 0.
- start_in sampled high at edge E0 in IDLE.
- After E0: busy_out=1 and vector 0 is on a_out/b_out.
- After edge Ek, vector k is driven.
- The results for vector k are checked at edge E(k+1+RESULT_LAT).
- The last check is at E(N+RESULT_LAT).
- After that same edge: done_out=1, busy_out=0, and err_count_out, fail_mask_out and pass_out are final.
- Total cycles from start acceptance to done: N + RESULT_LAT.
- The result ports are sampled only at clock edges; they must be settled by then.

## Test plan
- **Reset:** assert rst_n=0 with random inputs -> all outputs 0; start_in held high during reset has no effect.
- **Clean run:** DATA_WIDTH=4, RESULT_LAT=0, correct gate bank, start pulse -> busy_out for 256 cycles; done_out pulse after edge 256; err_count_out=0, pass_out=1, fail_mask_out=0.
- **Stuck-at fault:** xor_in[0] forced 0 -> err_count_out=128, fail_mask_out=7'b0100000, first_fail_a_out=0, first_fail_b_out=1, pass_out=0.
- **Latency:** RESULT_LAT=2 with the gate bank behind a 2-stage register -> pass, done after edge 258. The same 2-stage bank with RESULT_LAT=0 -> pass_out=0 and err_count_out>0.
- **Start ignored, reset mid-run:**
  - start_in pulses during RUN leave timing unchanged.
  - rst_n low at vector 100 -> all outputs 0.
  - A new start then completes 256 vectors with pass_out=1.
- **Minimum width:** DATA_WIDTH=1, RESULT_LAT=3, correct bank -> 4 vectors driven (00,01,10,11); done after edge 7; pass_out=1.
